candy_avb_pin_conditioner: RTL and testbench



---
 rtl/candy_avb_pin_conditioner.sv | 105 ++++++++++
 tb/tb_candy_avb_pin_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/candy_avb_pin_conditioner.sv
// Pad input conditioner: 2-flop synchronizer, debounce filter, and Avalon-MM level/edge/irq registers.
// Define CANDY_AVB_PIN_DEBOUNCE_EN to include the programmable debounce counter and length register.
module candy_avb_pin_conditioner #(
   parameter int unsigned      DEB_W     = 16,
   parameter logic [DEB_W-1:0] DEB_RESET = 'h00FF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        pad_in,
   output logic        cond_out,
   output logic        irq
);

   logic        s1_q, s2_q;
   logic        filt_q, filt_d;
   logic [1:0]  edge_q, edge_d, edge_set, edge_clr;
   logic [1:0]  mask_q;
   logic [31:0] readdata_q, readdata_d;
   logic        wr_en;
   logic        unused_wdata;

   assign wr_en        = chipselect && !write_n;
   assign unused_wdata = ^writedata;

`ifdef CANDY_AVB_PIN_DEBOUNCE_EN
   logic [DEB_W-1:0] cnt_q, cnt_d, len_q;

   // The >= compare lets a lowered len take effect on the very next mismatched cycle.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (s2_q == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q >= len_q) begin
         filt_d = s2_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         len_q <= DEB_RESET;
      end else begin
         cnt_q <= cnt_d;
         if (wr_en && address == 2'd1) len_q <= writedata[DEB_W-1:0];
      end
   end
`else
   logic [DEB_W-1:0] unused_deb_reset;

   assign filt_d           = s2_q;
   assign unused_deb_reset = DEB_RESET;
`endif

   // A new edge in the same cycle as its W1C clear survives: set is OR-ed in after the clear.
   assign edge_set = {filt_q & ~filt_d, ~filt_q & filt_d};
   assign edge_clr = (wr_en && address == 2'd2) ? writedata[1:0] : 2'b00;
   assign edge_d   = (edge_q & ~edge_clr) | edge_set;

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0: readdata_d = {31'd0, filt_q};
`ifdef CANDY_AVB_PIN_DEBOUNCE_EN
         2'd1: readdata_d = 32'(len_q);
`endif
         2'd2: readdata_d = {30'd0, edge_q};
         2'd3: readdata_d = {30'd0, mask_q};
         default: readdata_d = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         filt_q     <= 1'b1;
         edge_q     <= 2'b00;
         mask_q     <= 2'b00;
         readdata_q <= '0;
      end else begin
         s1_q       <= pad_in;
         s2_q       <= s1_q;
         filt_q     <= filt_d;
         edge_q     <= edge_d;
         readdata_q <= readdata_d;
         if (wr_en && address == 2'd3) mask_q <= writedata[1:0];
      end
   end

   assign readdata = readdata_q;
   assign cond_out = filt_q;
   assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_candy_avb_pin_conditioner.sv
// Randomized self-checking bench for candy_avb_pin_conditioner against a cycle-level behavioural model.
// Honours CANDY_AVB_PIN_DEBOUNCE_EN the same way the design does.
module tb_candy_avb_pin_conditioner;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = '0;
   logic [31:0] readdata;
   logic        pad_in     = 1'b1;
   logic        cond_out;
   logic        irq;

`ifdef CANDY_AVB_PIN_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   candy_avb_pin_conditioner dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .pad_in     (pad_in),
      .cond_out   (cond_out),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the pad is seen two edges late; a level differing from the
   // filtered one is adopted once it has differed for more than len consecutive cycles.
   bit          m_p1, m_p2, m_filt;
   int unsigned m_age, m_len;
   bit [1:0]    m_edge, m_mask;
   bit [31:0]   m_rd;

   function automatic void model_reset();
      m_p1 = 1'b1; m_p2 = 1'b1; m_filt = 1'b1;
      m_age = 0; m_len = 32'h00FF;
      m_edge = 2'b00; m_mask = 2'b00; m_rd = '0;
   endfunction

   function automatic bit [31:0] model_read(input bit [1:0] a);
      case (a)
         2'd0:    return {31'd0, m_filt};
         2'd1:    return DEB ? m_len : 32'd0;
         2'd2:    return {30'd0, m_edge};
         default: return {30'd0, m_mask};
      endcase
   endfunction

   function automatic void model_step();
      bit        wr;
      bit        nf;
      bit [1:0]  set_b, clr_b;
      bit [31:0] rd;
      wr = chipselect && !write_n;
      rd = model_read(address);
      nf = m_filt;
      if (!DEB) begin
         nf = m_p2;
      end else if (m_p2 != m_filt) begin
         m_age++;
         if (m_age > m_len) nf = m_p2;
      end
      if (nf == m_p2) m_age = 0;
      set_b  = {m_filt && !nf, !m_filt && nf};
      clr_b  = (wr && address == 2'd2) ? writedata[1:0] : 2'b00;
      m_edge = (m_edge & ~clr_b) | set_b;
      if (wr && address == 2'd3) m_mask = writedata[1:0];
      if (DEB && wr && address == 2'd1) m_len = writedata[15:0];
      m_filt = nf;
      m_p2   = m_p1;
      m_p1   = pad_in;
      m_rd   = rd;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("cond_out", cond_out, m_filt);
      check("irq", irq, |(m_edge & m_mask));
      check("readdata", readdata, m_rd);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cycle();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      cycle();
      d = readdata;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          n, lat, hold;

      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check("rst_cond_out", cond_out, 32'd1);
      check("rst_irq", irq, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      bus_read(2'd0, d); check("rst_level", d, 32'h1);
      bus_read(2'd1, d); check("rst_len", d, DEB ? 32'h00FF : 32'h0);
      bus_read(2'd2, d); check("rst_edge", d, 32'h0);
      bus_read(2'd3, d); check("rst_mask", d, 32'h0);

`ifdef CANDY_AVB_PIN_DEBOUNCE_EN
      bus_write(2'd1, 32'd4);
      lat = 7;
      pad_in = 1'b0; run(4);
      pad_in = 1'b1; run(8);
      check("glitch_cond_out", cond_out, 32'd1);
      bus_read(2'd2, d); check("glitch_edge", d, 32'h0);
`else
      lat = 3;
`endif

      bus_write(2'd3, 32'h2);
      pad_in = 1'b0;
      n = 0;
      while (cond_out !== 1'b0 && n < 40) begin
         cycle();
         n++;
      end
      check("fall_latency", n, lat);
      bus_read(2'd2, d); check("fall_edge", d, 32'h2);
      check("fall_irq", irq, 32'd1);

      pad_in = 1'b1;
      run(lat - 1);
      bus_write(2'd2, 32'h2);
      check("setwin_cond_out", cond_out, 32'd1);
      bus_read(2'd2, d); check("setwin_edge", d, 32'h1);
      check("setwin_irq", irq, 32'd0);

`ifdef CANDY_AVB_PIN_DEBOUNCE_EN
      bus_write(2'd1, 32'hFFFF);
      pad_in = 1'b0; run(12);
      check("longlen_hold", cond_out, 32'd1);
      bus_write(2'd1, 32'd3);
      check("lowerlen_wait", cond_out, 32'd1);
      cycle();
      check("lowerlen_accept", cond_out, 32'd0);
      bus_write(2'd1, 32'd20);
`else
      bus_write(2'd1, 32'h5);
      bus_read(2'd1, d); check("nodeb_len_ro", d, 32'h0);
`endif

      pad_in = !cond_out;
      run(5);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_cond_out", cond_out, 32'd1);
      check("midrst_irq", irq, 32'd0);
      check("midrst_readdata", readdata, 32'd0);
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      run(4);

      hold = 0;
      for (int i = 0; i < 2500; i++) begin
         if (hold == 0) begin
            pad_in = 1'($urandom_range(0, 1));
            hold   = $urandom_range(1, 12);
         end
         hold--;
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 3) == 0);
         write_n    = 1'($urandom_range(0, 1));
         writedata  = $urandom;
         if (address == 2'd1) writedata = $urandom_range(0, 6);
         cycle();
      end
      chipselect = 1'b0; write_n = 1'b1;
      run(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
